// File: rtl/entity_scan_ctrl.sv
// -----------------------------------------------------------------------------
// entity_scan_ctrl
//
// Walks an external entity table once per frame_start pulse and hands each
// entry downstream as a {type,row,col,index} record over a valid/ready link.
//
// Handshake: ent_valid is high only in PRESENT and the ent_* fields stay
// constant while it is high. A record is transferred on a rising edge where
// ent_valid && ent_ready. ent_ready is ignored in every other state.
//
// Table read timing: address_read_ent is registered here; the table returns
// data_read_ent one cycle after the address changes. FETCH is the cycle in
// which the table register loads, and LATCH samples the returned word.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   frame_start       one-cycle scan request (ignored and flagged while busy)
//   entities_number   number of valid table entries, sampled at scan start
//   address_read_ent  table address
//   data_read_ent     table word {type[20:18], row[17:9], col[8:0]}
//   ent_valid/ready   downstream record handshake
//   ent_type/row/col  captured record fields
//   ent_index         table address the record came from
//   busy              high in every state except IDLE
//   frame_done        one-cycle pulse at the end of a scan
//   ent_count         records transferred in the last completed scan
//   frame_overrun     sticky, set by frame_start while busy
//   state_dbg         current FSM state, for debug and checkers
//
// Build option: define ENT_SCAN_CLIP_EN to drop records whose row >= MAX_ROW
// or col >= MAX_COL instead of presenting them.
// -----------------------------------------------------------------------------
module entity_scan_ctrl #(
    parameter int MAX_ROW = 480,
    parameter int MAX_COL = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic [7:0]  entities_number,
    output logic [7:0]  address_read_ent,
    input  logic [20:0] data_read_ent,
    output logic        ent_valid,
    input  logic        ent_ready,
    output logic [2:0]  ent_type,
    output logic [8:0]  ent_row,
    output logic [8:0]  ent_col,
    output logic [7:0]  ent_index,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  ent_count,
    output logic        frame_overrun,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        LATCH   = 3'd2,
        PRESENT = 3'd3,
        DONE    = 3'd4
    } state_t;

`ifdef ENT_SCAN_CLIP_EN
    localparam logic CLIP_EN = 1'b1;
`else
    localparam logic CLIP_EN = 1'b0;
`endif

    state_t     state, state_n;
    logic [7:0] n_reg;
    logic [7:0] counter;
    logic       last_entry;
    logic       off_screen;
    logic       skip;
    logic       xfer;

    // The current address is the last one when addr+1 reaches n_reg; the
    // extra bit keeps 255+1 from wrapping to 0.
    assign last_entry = ({1'b0, address_read_ent} + 9'd1) >= {1'b0, n_reg};

    assign off_screen = (int'(data_read_ent[17:9]) >= MAX_ROW) ||
                        (int'(data_read_ent[8:0])  >= MAX_COL);
    assign skip       = CLIP_EN && (state == LATCH) && off_screen;
    assign xfer       = (state == PRESENT) && ent_ready;

    assign ent_valid  = (state == PRESENT);
    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);
    assign state_dbg  = state;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (frame_start) state_n = (entities_number == 8'd0) ? DONE : FETCH;
            FETCH:   state_n = LATCH;
            LATCH:   begin
                if (skip) state_n = last_entry ? DONE : FETCH;
                else      state_n = PRESENT;
            end
            PRESENT: if (ent_ready) state_n = last_entry ? DONE : FETCH;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            address_read_ent <= 8'd0;
            n_reg            <= 8'd0;
            counter          <= 8'd0;
            ent_type         <= 3'd0;
            ent_row          <= 9'd0;
            ent_col          <= 9'd0;
            ent_index        <= 8'd0;
            ent_count        <= 8'd0;
            frame_overrun    <= 1'b0;
        end else begin
            // A request that arrives in any non-IDLE state (DONE included)
            // is dropped but remembered.
            if (state != IDLE && frame_start) frame_overrun <= 1'b1;

            if (state == IDLE && frame_start) begin
                n_reg            <= entities_number;
                address_read_ent <= 8'd0;
                counter          <= 8'd0;
                frame_overrun    <= 1'b0;
            end

            if (state == LATCH && !skip) begin
                ent_type  <= data_read_ent[20:18];
                ent_row   <= data_read_ent[17:9];
                ent_col   <= data_read_ent[8:0];
                ent_index <= address_read_ent;
            end

            if (xfer) counter <= counter + 8'd1;

            if ((xfer || skip) && !last_entry) address_read_ent <= address_read_ent + 8'd1;

            if (state == DONE) ent_count <= counter;
        end
    end

endmodule

// File: tb/tb_entity_scan_ctrl.sv
// -----------------------------------------------------------------------------
// Directed bench for entity_scan_ctrl. Cycle k means "observed on the falling
// edge after the k-th rising edge counted from the one that sampled
// frame_start" (k = 0 is that edge).
// -----------------------------------------------------------------------------
module tb_entity_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        frame_start;
    logic [7:0]  entities_number;
    logic [7:0]  address_read_ent;
    logic [20:0] data_read_ent;
    logic        ent_valid;
    logic        ent_ready;
    logic [2:0]  ent_type;
    logic [8:0]  ent_row;
    logic [8:0]  ent_col;
    logic [7:0]  ent_index;
    logic        busy;
    logic        frame_done;
    logic [7:0]  ent_count;
    logic        frame_overrun;
    logic [2:0]  state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    // Entity table with a one-cycle registered read.
    logic [20:0] tbl [0:255];

    // Results collected by run_scan.
    logic [7:0]  got_idx_q [$];
    logic [20:0] got_word_q[$];
    int          got_cyc_q [$];
    int          done_cyc;

    entity_scan_ctrl #(.MAX_ROW(480), .MAX_COL(480)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .frame_start      (frame_start),
        .entities_number  (entities_number),
        .address_read_ent (address_read_ent),
        .data_read_ent    (data_read_ent),
        .ent_valid        (ent_valid),
        .ent_ready        (ent_ready),
        .ent_type         (ent_type),
        .ent_row          (ent_row),
        .ent_col          (ent_col),
        .ent_index        (ent_index),
        .busy             (busy),
        .frame_done       (frame_done),
        .ent_count        (ent_count),
        .frame_overrun    (frame_overrun),
        .state_dbg        (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) data_read_ent <= tbl[address_read_ent];

    task automatic load_table();
        for (int i = 0; i < 256; i++) begin
            logic [7:0] iv;
            iv = 8'(i);
            tbl[i] = {iv[2:0], {1'b0, iv}, {1'b0, 8'(255 - i)}};
        end
        tbl[0] = {3'd0, 9'd0,   9'd150};
        tbl[1] = {3'd1, 9'd200, 9'd300};
        tbl[2] = {3'd2, 9'd350, 9'd0};
    endtask

    // ---------------- driver ----------------
    // Pulses frame_start with entities_number = n and ent_ready held high,
    // then records every presented record until frame_done or the budget
    // runs out. entities_number is changed right after the start to show it
    // has no effect; frame_start is re-pulsed at cycle inject_cyc if >= 0.
    task automatic run_scan(input int n, input int inject_cyc, input int budget);
        int k;
        got_idx_q.delete();
        got_word_q.delete();
        got_cyc_q.delete();
        done_cyc = -1;
        @(negedge clk);
        entities_number = 8'(n);
        ent_ready   = 1'b1;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start     = 1'b0;
        entities_number = 8'(n + 2);
        k = 0;
        while (done_cyc < 0 && k < budget) begin
            if (ent_valid) begin
                got_idx_q.push_back(ent_index);
                got_word_q.push_back({ent_type, ent_row, ent_col});
                got_cyc_q.push_back(k);
            end
            if (frame_done) done_cyc = k;
            frame_start = (k == inject_cyc);
            @(negedge clk);
            k++;
        end
        frame_start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        frame_start = 1'b0;
        entities_number = 8'd0;
        ent_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({address_read_ent, ent_valid, ent_type, ent_row, ent_col, ent_index,
             busy, frame_done, ent_count, frame_overrun, state_dbg} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: addr=%0d valid=%b busy=%b done=%b count=%0d ovr=%b state=%0d, required all 0",
                     address_read_ent, ent_valid, busy, frame_done, ent_count, frame_overrun, state_dbg);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || ent_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b valid=%b, required 0 0", busy, ent_valid);
        end
    endtask

    task automatic test_basic();
        int exp_cyc[3] = '{2, 5, 8};
        run_scan(3, -1, 40);
        n_checks++;
        if (got_idx_q.size() != 3) begin
            n_fail++;
            $display("FAIL basic_count_seen: got %0d records, required 3", got_idx_q.size());
        end
        for (int i = 0; i < 3 && i < got_idx_q.size(); i++) begin
            n_checks++;
            if (got_idx_q[i] !== 8'(i) || got_word_q[i] !== tbl[i] || got_cyc_q[i] != exp_cyc[i]) begin
                n_fail++;
                $display("FAIL basic_record%0d: idx=%0d word=%h cyc=%0d, required idx=%0d word=%h cyc=%0d",
                         i, got_idx_q[i], got_word_q[i], got_cyc_q[i], i, tbl[i], exp_cyc[i]);
            end
        end
        n_checks++;
        if (done_cyc != 9) begin
            n_fail++;
            $display("FAIL basic_done_cycle: %0d, required 9", done_cyc);
        end
        n_checks++;
        if (ent_count !== 8'd3 || busy !== 1'b0 || frame_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_end_state: count=%0d busy=%b ovr=%b, required 3 0 0", ent_count, busy, frame_overrun);
        end
    endtask

    task automatic test_stall();
        int k;
        int hold;
        int nrec;
        int dcyc;
        logic [20:0] word;
        hold = 0;
        nrec = 0;
        dcyc = -1;
        @(negedge clk);
        entities_number = 8'd3;
        ent_ready   = 1'b1;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        k = 0;
        while (dcyc < 0 && k < 60) begin
            ent_ready = 1'b1;
            if (ent_valid) begin
                word = {ent_type, ent_row, ent_col};
                if (ent_index == 8'd1) begin
                    hold++;
                    n_checks++;
                    if (word !== {3'd1, 9'd200, 9'd300}) begin
                        n_fail++;
                        $display("FAIL stall_hold_fields: cyc=%0d word=%h, required %h",
                                 k, word, {3'd1, 9'd200, 9'd300});
                    end
                    if (hold <= 4) ent_ready = 1'b0;
                end
                if (hold == 0 || hold == 5 || ent_index != 8'd1) nrec++;
            end
            if (frame_done) dcyc = k;
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (hold != 5 || nrec != 3) begin
            n_fail++;
            $display("FAIL stall_hold_len: hold=%0d records=%0d, required 5 3", hold, nrec);
        end
        n_checks++;
        if (dcyc != 13 || ent_count !== 8'd3) begin
            n_fail++;
            $display("FAIL stall_done: cyc=%0d count=%0d, required 13 3", dcyc, ent_count);
        end
    endtask

    task automatic test_zero();
        @(negedge clk);
        entities_number = 8'd0;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        n_checks++;
        if (frame_done !== 1'b1 || ent_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_done_pulse: done=%b valid=%b, required 1 0", frame_done, ent_valid);
        end
        @(negedge clk);
        n_checks++;
        if (frame_done !== 1'b0 || busy !== 1'b0 || ent_count !== 8'd0 || ent_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_after: done=%b busy=%b count=%0d valid=%b, required 0 0 0 0",
                     frame_done, busy, ent_count, ent_valid);
        end
    endtask

    task automatic test_overrun();
        run_scan(3, 5, 40);
        n_checks++;
        if (frame_overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_flag: %b, required 1", frame_overrun);
        end
        n_checks++;
        if (got_idx_q.size() != 3 || done_cyc != 9 || ent_count !== 8'd3) begin
            n_fail++;
            $display("FAIL overrun_scan: records=%0d done=%0d count=%0d, required 3 9 3",
                     got_idx_q.size(), done_cyc, ent_count);
        end
        // frame_start during the DONE cycle is also an overrun.
        run_scan(0, 0, 10);
        n_checks++;
        if (frame_overrun !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_in_done: ovr=%b busy=%b, required 1 0", frame_overrun, busy);
        end
        @(negedge clk);
        entities_number = 8'd3;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        n_checks++;
        if (frame_overrun !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_clear: ovr=%b busy=%b, required 0 1", frame_overrun, busy);
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        entities_number = 8'd3;
        ent_ready   = 1'b1;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (ent_valid !== 1'b1 || ent_index !== 8'd1) begin
            n_fail++;
            $display("FAIL rstmid_pre: valid=%b idx=%0d, required 1 1", ent_valid, ent_index);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({address_read_ent, ent_valid, ent_type, ent_row, ent_col, ent_index,
             busy, frame_done, ent_count, frame_overrun, state_dbg} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_async: addr=%0d valid=%b idx=%0d busy=%b count=%0d state=%0d, required all 0",
                     address_read_ent, ent_valid, ent_index, busy, ent_count, state_dbg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (ent_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_idle: cyc=%0d valid=%b busy=%b, required 0 0", i, ent_valid, busy);
            end
        end
    endtask

    task automatic test_clip();
        logic [7:0] exp_idx_q[$];
        tbl[1] = {3'd1, 9'd500, 9'd300};
`ifdef ENT_SCAN_CLIP_EN
        exp_idx_q = '{8'd0, 8'd2};
`else
        exp_idx_q = '{8'd0, 8'd1, 8'd2};
`endif
        run_scan(3, -1, 40);
        n_checks++;
        if (got_idx_q != exp_idx_q || ent_count !== 8'(exp_idx_q.size())) begin
            n_fail++;
            $display("FAIL clip_records: seen=%0d count=%0d, required %0d %0d",
                     got_idx_q.size(), ent_count, exp_idx_q.size(), exp_idx_q.size());
        end
        tbl[1] = {3'd1, 9'd200, 9'd300};
    endtask

    task automatic test_max();
        logic ok;
        run_scan(255, -1, 1000);
        ok = (got_idx_q.size() == 255);
        for (int i = 0; ok && i < 255; i++)
            if (got_idx_q[i] !== 8'(i) || got_word_q[i] !== tbl[i]) ok = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL max_records: seen=%0d, required 255 in order 0..254", got_idx_q.size());
        end
        n_checks++;
        if (done_cyc != 765 || ent_count !== 8'd255 || address_read_ent !== 8'd254) begin
            n_fail++;
            $display("FAIL max_end: done=%0d count=%0d addr=%0d, required 765 255 254",
                     done_cyc, ent_count, address_read_ent);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        load_table();
        test_reset();
        test_basic();
        test_stall();
        test_zero();
        test_overrun();
        test_reset_mid();
        test_clip();
        test_max();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/entity_scan_ctrl.md
ENTITY_SCAN_CTRL -- requirements
Module: entity_scan_ctrl

Interface
REQ-001 Parameter: MAX_ROW, 480, exclusive row bound for on-screen test.
REQ-002 Parameter: MAX_COL, 480, exclusive column bound for on-screen test.
REQ-003 Ports: clk  in  1  single clock, all state on rising edge.
REQ-004 Ports: rst_n  in  1  asynchronous, active-low reset.
REQ-005 Ports: frame_start  in  1  one-cycle pulse requesting a scan of the entity table.
REQ-006 Ports: entities_number  in  8  count of valid table entries.
REQ-007 Ports: address_read_ent  out  8  registered table address.
REQ-008 Ports: data_read_ent  in  21  table word {type[20:18], row[17:9], col[8:0]}, valid one cycle after address changes.
REQ-009 Ports: ent_valid  out  1  entity record presented downstream.
REQ-010 Ports: ent_ready  in  1  downstream accepts record.
REQ-011 Ports: ent_type / ent_row / ent_col / ent_index  out  3/9/9/8  captured record fields and its table address.
REQ-012 Ports: busy  out  1  high in any state except IDLE.
REQ-013 Ports: frame_done  out  1  one-cycle pulse at end of scan.
REQ-014 Ports: ent_count  out  8  records transferred in the last completed scan.
REQ-015 Ports: frame_overrun  out  1  sticky: frame_start arrived while busy.

Function
REQ-016 FSM states IDLE, FETCH, LATCH, PRESENT, DONE; one state per cycle except PRESENT.
REQ-017 IDLE: frame_start=1 -> latch entities_number into n_reg, address_read_ent<=0, clear transfer counter and frame_overrun; go FETCH, or DONE if entities_number=0.
REQ-018 FETCH -> LATCH unconditionally (table register updates on this edge).
REQ-019 LATCH: capture data_read_ent fields and address into ent_* registers; go PRESENT.
REQ-020 PRESENT: ent_valid=1; ent_* stable until ent_valid&&ent_ready.
REQ-021 On transfer: counter+1; if address_read_ent+1 < n_reg then address+1, go FETCH; else go DONE.
REQ-022 DONE: frame_done=1 for exactly this cycle, ent_count<=counter, go IDLE.
REQ-023 Latency: first ent_valid two cycles after the edge sampling frame_start; back-to-back throughput one record per 3 cycles with ent_ready held high.
REQ-024 frame_start while busy: ignored, frame_overrun<=1; scan continues unaffected.
REQ-025 frame_start in DONE cycle: treated as busy (ignored, overrun set).
REQ-026 Changes to entities_number mid-scan have no effect; n_reg used.
REQ-027 n_reg=255 max: address never wraps; last address 254.
REQ-028 ent_ready outside PRESENT is ignored.

Reset
REQ-029 rst_n=0 at any time, including mid-scan: state IDLE, address_read_ent=0, ent_valid=0, ent_type/row/col/index=0, busy=0, frame_done=0, ent_count=0, frame_overrun=0, n_reg=0, counter=0.
REQ-030 After release, no scan begins until a new frame_start.

Configuration
REQ-031 Macro ENT_SCAN_CLIP_EN defined: in LATCH, record with row>=MAX_ROW or col>=MAX_COL is not presented; FSM goes directly to FETCH (next address) or DONE as in REQ-021, counter not incremented.
REQ-032 Macro ENT_SCAN_CLIP_EN undefined: every entry is presented; MAX_ROW/MAX_COL unused.

Verification
REQ-033 Table {(0,0,150),(1,200,300),(2,350,0)}, n=3, ready=1, pulse frame_start -> three records in order, index 0,1,2, ent_valid at cycles +2,+5,+8, frame_done at +9, ent_count=3.
REQ-034 Same table, ent_ready low 4 cycles on record 1 -> ent_type=1,row=200,col=300 held stable 5 cycles, then continue; ent_count=3.
REQ-035 entities_number=0, frame_start -> no ent_valid, frame_done one cycle after start edge, ent_count=0.
REQ-036 frame_start re-pulsed during record 1 -> frame_overrun=1, scan ends normally with ent_count=3; next accepted frame_start clears frame_overrun.
REQ-037 rst_n low during PRESENT of record 1 -> all outputs 0 asynchronously, IDLE after release, no ent_valid without new frame_start.
REQ-038 ENT_SCAN_CLIP_EN, entry 1 row=500 -> only indices 0 and 2 presented, ent_count=2; without macro -> 3 presented.
